// File: rtl/uart_decoder.sv
// uart_decoder: 8N1 UART receiver with runtime bit period, mid-bit sampling.
//   i_Clk, i_Rst_L     : clock (rising edge), async active-low reset
//   i_Period[19:0]     : clocks per bit (0/1 treated as 2), latched at start detect
//   i_UART_RX          : serial line, idle high, asynchronous to i_Clk
//   o_Byte[7:0]        : last good received byte, holds between frames
//   o_valid            : one-cycle strobe, o_Byte new in the same cycle
//   o_busy             : high while a frame is being received
//   o_framing_error    : one-cycle strobe when stop (or parity) check fails
// Optional feature: define UART_DECODER_PARITY_EN for an even-parity bit (8E1).
module uart_decoder (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic [19:0] i_Period,
  input  logic        i_UART_RX,
  output logic [7:0]  o_Byte,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_framing_error
);

  localparam int unsigned PW = 20;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic          r_rx_meta, r_rx_s, r_rx_d;
  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_period, w_period_nxt;
  logic [PW-1:0] r_cnt, w_cnt_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [DW-1:0] r_shift, w_shift_nxt;
  logic [DW-1:0] r_byte, w_byte_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_ferr, w_ferr_nxt;
  logic          r_busy, w_busy_nxt;
  logic [PW-1:0] w_half;
  logic          w_bit_hit;
  logic          w_stop_ok;
`ifdef UART_DECODER_PARITY_EN
  logic          r_par_ok, w_par_ok_nxt;
`endif

  // Two-flop synchronizer plus one delay flop for falling-edge detection
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= i_UART_RX;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  assign w_half    = r_period >> 1;
  assign w_bit_hit = (r_cnt == r_period - PW'(1));
`ifdef UART_DECODER_PARITY_EN
  assign w_stop_ok = r_rx_s && r_par_ok;
`else
  assign w_stop_ok = r_rx_s;
`endif

  // State register and datapath registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state  <= S_IDLE;
      r_period <= PW'(2);
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_byte   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef UART_DECODER_PARITY_EN
      r_par_ok <= 1'b1;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_period <= w_period_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_byte   <= w_byte_nxt;
      r_valid  <= w_valid_nxt;
      r_ferr   <= w_ferr_nxt;
      r_busy   <= w_busy_nxt;
`ifdef UART_DECODER_PARITY_EN
      r_par_ok <= w_par_ok_nxt;
`endif
    end
  end

  // Next-state and output logic; bit counter wraps to 0 at every sample point
  always_comb begin
    w_state_nxt  = r_state;
    w_period_nxt = r_period;
    w_cnt_nxt    = r_cnt + PW'(1);
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_byte_nxt   = r_byte;
    w_valid_nxt  = 1'b0;
    w_ferr_nxt   = 1'b0;
`ifdef UART_DECODER_PARITY_EN
    w_par_ok_nxt = r_par_ok;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (r_rx_d && !r_rx_s) begin
          w_period_nxt = (i_Period < PW'(2)) ? PW'(2) : i_Period;
          w_idx_nxt    = '0;
          w_state_nxt  = S_START;
        end
      end
      S_START: begin
        if (r_cnt == w_half - PW'(1)) begin
          w_cnt_nxt   = '0;
          // A high line at mid start bit is a glitch: abandon silently
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_hit) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_s, r_shift[DW-1:1]};
          w_idx_nxt   = r_idx + IW'(1);
          if (r_idx == IW'(DW - 1)) begin
`ifdef UART_DECODER_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
      S_PARITY: begin
`ifdef UART_DECODER_PARITY_EN
        if (w_bit_hit) begin
          w_cnt_nxt    = '0;
          w_par_ok_nxt = ~(^{r_shift, r_rx_s});
          w_state_nxt  = S_STOP;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      S_STOP: begin
        if (w_bit_hit) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          if (w_stop_ok) begin
            w_byte_nxt  = r_shift;
            w_valid_nxt = 1'b1;
          end else begin
            w_ferr_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign o_Byte          = r_byte;
  assign o_valid         = r_valid;
  assign o_busy          = r_busy;
  assign o_framing_error = r_ferr;

endmodule

// File: tb/tb_uart_decoder.sv
// Testbench for uart_decoder: serial driver, expected-event queue, negedge monitor.
module tb_uart_decoder;

`ifdef UART_DECODER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic       err;
    logic [7:0] b;
  } exp_t;

  logic        i_Clk = 1'b0;
  logic        i_Rst_L;
  logic [19:0] i_Period;
  logic        i_UART_RX;
  logic [7:0]  o_Byte;
  logic        o_valid;
  logic        o_busy;
  logic        o_framing_error;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  logic [7:0] exp_last = 8'h00;
  bit   gap_en = 1'b0;
  bit   have_prev = 1'b0;
  int   last_valid_cyc = 0;
  bit   busy_seen = 1'b0;

  uart_decoder dut (
    .i_Clk           (i_Clk),
    .i_Rst_L         (i_Rst_L),
    .i_Period        (i_Period),
    .i_UART_RX       (i_UART_RX),
    .o_Byte          (o_Byte),
    .o_valid         (o_valid),
    .o_busy          (o_busy),
    .o_framing_error (o_framing_error)
  );

  always #5 i_Clk = ~i_Clk;
  always @(posedge i_Clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Output monitor: every strobe must match the head of the expected queue
  always @(negedge i_Clk) begin
    if (i_Rst_L) begin
      if (o_busy) busy_seen = 1'b1;
      if (o_valid) begin
        check("busy_low_in_valid", 32'(o_busy), 32'd0);
        if (gap_en) begin
          if (have_prev) check("valid_gap", 32'(cyc - last_valid_cyc), 32'd160);
          last_valid_cyc = cyc;
          have_prev = 1'b1;
        end
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 32'(o_Byte), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("valid_kind", 32'(1'b0), 32'(e.err));
          check("valid_byte", 32'(o_Byte), 32'(e.b));
        end
      end
      if (o_framing_error) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ferr", 32'(o_Byte), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("ferr_kind", 32'(1'b1), 32'(e.err));
          check("ferr_byte_held", 32'(o_Byte), 32'(e.b));
        end
      end
    end
  end

  task automatic send_bit(input logic b, input int p);
    i_UART_RX = b;
    repeat (p) @(posedge i_Clk);
    #1;
  endtask

  // Drives one frame and pushes the expected outcome
  task automatic send_frame(input logic [7:0] b, input int p, input logic stop_v,
                            input logic par_flip);
    exp_t e;
    logic ok;
    ok = stop_v && !(PAR_EN && par_flip);
    e.err = !ok;
    e.b   = ok ? b : exp_last;
    if (ok) exp_last = b;
    sb_q.push_back(e);
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) send_bit(b[i], p);
`ifdef UART_DECODER_PARITY_EN
    send_bit((^b) ^ par_flip, p);
`endif
    send_bit(stop_v, p);
  endtask

  task automatic drain(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && sb_q.size() != 0; i++) @(posedge i_Clk);
    repeat (2) @(posedge i_Clk);
    #1;
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] partial;
    i_Rst_L   = 1'b0;
    i_UART_RX = 1'b1;
    i_Period  = 20'd2;
    repeat (3) @(posedge i_Clk);
    #1;
    check("rst_byte", 32'(o_Byte), 32'h00);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ferr", 32'(o_framing_error), 32'd0);
    i_Rst_L = 1'b1;
    repeat (4) @(posedge i_Clk);
    #1;

    // Minimum period
    i_Period = 20'd2;
    send_frame(8'h8A, 2, 1'b1, 1'b0);
    drain("drain_p2", 100);
    check("p2_byte", 32'(o_Byte), 32'h8A);

    // Period values 0 and 1 behave as 2
    i_Period = 20'd0;
    send_frame(8'h3E, 2, 1'b1, 1'b0);
    drain("drain_p0", 100);
    i_Period = 20'd1;
    send_frame(8'hC3, 2, 1'b1, 1'b0);
    drain("drain_p1", 100);
    repeat (5) @(posedge i_Clk);
    #1;

    // Back-to-back frames, exact 10P spacing
    i_Period  = 20'd16;
    gap_en    = 1'b1;
    have_prev = 1'b0;
    send_frame(8'h00, 16, 1'b1, 1'b0);
    send_frame(8'hFF, 16, 1'b1, 1'b0);
    send_frame(8'h55, 16, 1'b1, 1'b0);
    drain("drain_b2b", 200);
    gap_en = 1'b0;
    check("b2b_byte", 32'(o_Byte), 32'h55);

    // Stop bit low with line held low, then recovery; i_Period change mid-frame ignored
    i_Period = 20'd8;
    send_frame(8'hA5, 8, 1'b0, 1'b0);
    send_bit(1'b0, 16);
    drain("drain_ferr", 50);
    check("ferr_byte_kept", 32'(o_Byte), 32'h55);
    send_bit(1'b1, 20);
    fork
      send_frame(8'h3C, 8, 1'b1, 1'b0);
      begin
        repeat (20) @(posedge i_Clk);
        #1;
        i_Period = 20'd3;
      end
    join
    drain("drain_recover", 100);
    check("recover_byte", 32'(o_Byte), 32'h3C);
    i_Period = 20'd8;

    // Start glitch shorter than half a bit
    i_Period  = 20'd16;
    busy_seen = 1'b0;
    i_UART_RX = 1'b0;
    repeat (4) @(posedge i_Clk);
    #1;
    i_UART_RX = 1'b1;
    repeat (40) @(posedge i_Clk);
    #1;
    check("glitch_busy_rose", 32'(busy_seen), 32'd1);
    check("glitch_busy_fell", 32'(o_busy), 32'd0);
    check("glitch_byte", 32'(o_Byte), 32'h3C);

    // Reset in the middle of bit 4
    i_Period = 20'd8;
    partial  = 8'h5A;
    send_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) send_bit(partial[i], 8);
    i_UART_RX = partial[4];
    repeat (3) @(posedge i_Clk);
    #1;
    check("mid_busy", 32'(o_busy), 32'd1);
    i_Rst_L = 1'b0;
    #1;
    check("midrst_byte", 32'(o_Byte), 32'h00);
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_ferr", 32'(o_framing_error), 32'd0);
    exp_last = 8'h00;
    i_UART_RX = 1'b1;
    repeat (4) @(posedge i_Clk);
    #1;
    i_Rst_L = 1'b1;
    repeat (5) @(posedge i_Clk);
    #1;
    send_frame(8'h81, 8, 1'b1, 1'b0);
    drain("drain_after_rst", 100);
    check("after_rst_byte", 32'(o_Byte), 32'h81);

`ifdef UART_DECODER_PARITY_EN
    send_frame(8'h07, 8, 1'b1, 1'b0);
    drain("drain_par_good", 100);
    send_frame(8'h07, 8, 1'b1, 1'b1);
    drain("drain_par_bad", 100);
    check("par_byte", 32'(o_Byte), 32'h07);
`endif

    repeat (10) @(posedge i_Clk);
    #1;
    check("final_queue_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
